// File: rtl/minibyte_memio_resp.sv
// ---------------------------------------------------------------------------
// minibyte_memio_resp
//
// Memory/IO responder for the minibyte CPU bus. The CPU's addr/data/we
// outputs are decoded here and read data is returned combinationally from
// the current address. Contents:
//   - byte RAM at 0x00..RAM_DEPTH-1 (not reset)
//   - GPIO output register (0xF0, R/W)
//   - GPIO input through a 2-flop synchroniser (0xF1, read-only)
//   - TX byte FIFO draining to a ready/valid stream (0xF2 push / count)
//   - status (0xF3) = {4'b0, overflow, expired, full, empty}; write clears
//     overflow
//   - optional down-counting timer (0xF4 reload, 0xF5 count), compiled in
//     only when the macro MINIBYTE_TIMER_EN is defined; without it 0xF4/0xF5
//     read 0x00 and the expired status bit is tied low
//
// Parameters:
//   RAM_DEPTH  : RAM bytes, power of 2, 2..128
//   FIFO_DEPTH : TX FIFO entries, power of 2, 2..8
//
// Ports:
//   clk_in    in   1  system clock, rising edge
//   rst_in    in   1  synchronous active-high reset
//   addr_in   in   8  CPU address
//   data_in   in   8  CPU write data
//   we_in     in   1  CPU write enable
//   data_out  out  8  read data, combinational from addr_in
//   gpio_in   in   8  asynchronous external inputs
//   gpio_out  out  8  GPIO output register
//   tx_data   out  8  FIFO head byte (registered)
//   tx_valid  out  1  FIFO non-empty
//   tx_ready  in   1  downstream accepts tx_data this cycle
// ---------------------------------------------------------------------------
module minibyte_memio_resp #(
  parameter int RAM_DEPTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic       we_in,
  output logic [7:0] data_out,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [8:0]       RAM_LIMIT     = 9'(RAM_DEPTH);
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] ADDR_GPIO_OUT = 8'hF0;
  localparam logic [7:0] ADDR_GPIO_IN  = 8'hF1;
  localparam logic [7:0] ADDR_FIFO     = 8'hF2;
  localparam logic [7:0] ADDR_STATUS   = 8'hF3;
`ifdef MINIBYTE_TIMER_EN
  localparam logic [7:0] ADDR_RELOAD   = 8'hF4;
  localparam logic [7:0] ADDR_COUNT    = 8'hF5;
`endif

  // -------------------------------------------------------------------------
  // Address decode. Writes in a reset cycle are dropped everywhere,
  // including the RAM, which otherwise has no reset.
  // -------------------------------------------------------------------------
  logic sel_ram;
  logic wr_en;
  logic wr_gpio;
  logic wr_fifo;
  logic wr_status;

  assign sel_ram   = ({1'b0, addr_in} < RAM_LIMIT);
  assign wr_en     = we_in && !rst_in;
  assign wr_gpio   = wr_en && (addr_in == ADDR_GPIO_OUT);
  assign wr_fifo   = wr_en && (addr_in == ADDR_FIFO);
  assign wr_status = wr_en && (addr_in == ADDR_STATUS);

  // -------------------------------------------------------------------------
  // Byte RAM
  // -------------------------------------------------------------------------
  logic [7:0] ram [RAM_DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en && sel_ram) begin
      ram[addr_in[RAM_AW-1:0]] <= data_in;
    end
  end

  // -------------------------------------------------------------------------
  // GPIO output register and input synchroniser
  // -------------------------------------------------------------------------
  logic [7:0] gpio_out_q;
  logic [7:0] gpio_sync1;
  logic [7:0] gpio_sync2;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gpio_out_q <= 8'h00;
      gpio_sync1 <= 8'h00;
      gpio_sync2 <= 8'h00;
    end else begin
      if (wr_gpio) begin
        gpio_out_q <= data_in;
      end
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
    end
  end

  assign gpio_out = gpio_out_q;

  // -------------------------------------------------------------------------
  // TX FIFO
  // tx_data is a dedicated register holding the head entry rather than a
  // mux off the storage array: it stays put while stalled and keeps the
  // last popped byte once the FIFO runs empty.
  // -------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] fifo_cnt_nxt;
  logic [7:0]       tx_data_q;
  logic [7:0]       head_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;
  logic             push_reject;

  assign fifo_full   = (fifo_cnt == FIFO_FULL_CNT);
  assign fifo_empty  = (fifo_cnt == '0);
  assign pop         = !fifo_empty && tx_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok     = wr_fifo && (!fifo_full || pop);
  assign push_reject = wr_fifo && !push_ok;

  assign rd_ptr_nxt   = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
  assign fifo_cnt_nxt = fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);

  always_comb begin
    head_nxt = tx_data_q;
    if (fifo_cnt_nxt != '0) begin
      // When every stored entry is consumed this cycle, the incoming byte
      // becomes the head before it is visible in fifo_mem.
      if (push_ok && (fifo_cnt == CNT_W'(pop))) begin
        head_nxt = data_in;
      end else begin
        head_nxt = fifo_mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      tx_data_q <= 8'h00;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_ptr_nxt;
      fifo_cnt  <= fifo_cnt_nxt;
      tx_data_q <= head_nxt;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = !fifo_empty;

  // -------------------------------------------------------------------------
  // Sticky overflow flag; a rejected push beats a clearing write.
  // -------------------------------------------------------------------------
  logic overflow_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow_q <= 1'b0;
    end else if (push_reject) begin
      overflow_q <= 1'b1;
    end else if (wr_status) begin
      overflow_q <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Optional timer
  // Count runs down while reload is non-zero; on reaching 1 it reloads on
  // the next edge and raises the sticky expired flag. A reload write takes
  // priority over the tick in the same cycle.
  // -------------------------------------------------------------------------
  logic expired;

`ifdef MINIBYTE_TIMER_EN
  logic [7:0] timer_reload;
  logic [7:0] timer_cnt;
  logic       timer_expired_q;
  logic       wr_reload;
  logic       wr_count;
  logic       timer_wrap;

  assign wr_reload  = wr_en && (addr_in == ADDR_RELOAD);
  assign wr_count   = wr_en && (addr_in == ADDR_COUNT);
  assign timer_wrap = !wr_reload && (timer_reload != 8'h00) &&
                      (timer_cnt == 8'h01);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      timer_reload <= 8'h00;
      timer_cnt    <= 8'h00;
    end else if (wr_reload) begin
      timer_reload <= data_in;
      timer_cnt    <= data_in;
    end else if (timer_reload != 8'h00) begin
      if (timer_cnt == 8'h01) begin
        timer_cnt <= timer_reload;
      end else begin
        timer_cnt <= timer_cnt - 8'h01;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      timer_expired_q <= 1'b0;
    end else if (timer_wrap) begin
      timer_expired_q <= 1'b1;
    end else if (wr_count) begin
      timer_expired_q <= 1'b0;
    end
  end

  assign expired = timer_expired_q;
`else
  assign expired = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  always_comb begin
    data_out = 8'h00;
    if (sel_ram) begin
      data_out = ram[addr_in[RAM_AW-1:0]];
    end else begin
      case (addr_in)
        ADDR_GPIO_OUT: data_out = gpio_out_q;
        ADDR_GPIO_IN:  data_out = gpio_sync2;
        ADDR_FIFO:     data_out = 8'(fifo_cnt);
        ADDR_STATUS:   data_out = {4'b0000, overflow_q, expired,
                                   fifo_full, fifo_empty};
`ifdef MINIBYTE_TIMER_EN
        ADDR_RELOAD:   data_out = timer_reload;
        ADDR_COUNT:    data_out = timer_cnt;
`endif
        default:       data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_minibyte_memio_resp.sv
`timescale 1ns/1ps
module tb_minibyte_memio_resp;

  localparam int RAM_DEPTH  = 32;
  localparam int FIFO_DEPTH = 4;
`ifdef MINIBYTE_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] addr_in = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic       we_in = 1'b0;
  logic [7:0] data_out;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  minibyte_memio_resp #(.RAM_DEPTH(RAM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .addr_in(addr_in), .data_in(data_in),
    .we_in(we_in), .data_out(data_out), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural reference: RAM array, byte queue for the FIFO, flags.
  logic [7:0] m_ram [RAM_DEPTH];
  logic [7:0] m_q [$];
  logic [7:0] m_gpio_out = 8'h00;
  logic [7:0] m_last_head = 8'h00;
  logic [7:0] m_s1 = 8'h00;
  logic [7:0] m_s2 = 8'h00;
  logic [7:0] m_reload = 8'h00;
  logic [7:0] m_tcnt = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_exp = 1'b0;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (int'(a) < RAM_DEPTH) return m_ram[int'(a)];
    case (a)
      8'hF0: return m_gpio_out;
      8'hF1: return m_s2;
      8'hF2: return 8'(m_q.size());
      8'hF3: return {4'b0000, m_ovf, m_exp, m_q.size() == FIFO_DEPTH, m_q.size() == 0};
      8'hF4: return TIMER_EN ? m_reload : 8'h00;
      8'hF5: return TIMER_EN ? m_tcnt : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_edge(input logic [7:0] a, input logic [7:0] d, input logic we,
                        input logic ready, input logic [7:0] gin, input logic rst);
    bit pop, push, accept, wrap;
    if (rst) begin
      m_q.delete();
      m_ovf = 0; m_exp = 0; m_gpio_out = 0; m_last_head = 0;
      m_s1 = 0; m_s2 = 0; m_reload = 0; m_tcnt = 0;
      return;
    end
    pop    = (m_q.size() > 0) && ready;
    push   = we && (a == 8'hF2);
    accept = push && ((m_q.size() < FIFO_DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (accept) m_q.push_back(d);
    if (push && !accept) m_ovf = 1;
    else if (we && a == 8'hF3) m_ovf = 0;
    if (m_q.size() > 0) m_last_head = m_q[0];
    if (we && a == 8'hF0) m_gpio_out = d;
    if (we && int'(a) < RAM_DEPTH) m_ram[int'(a)] = d;
    m_s2 = m_s1;
    m_s1 = gin;
    if (TIMER_EN) begin
      wrap = 0;
      if (we && a == 8'hF4) begin
        m_reload = d;
        m_tcnt = d;
      end else if (m_reload != 0) begin
        if (m_tcnt == 1) begin
          m_tcnt = m_reload;
          wrap = 1;
        end else begin
          m_tcnt = m_tcnt - 1;
        end
      end
      if (we && a == 8'hF5) m_exp = 0;
      if (wrap) m_exp = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    m_edge(addr_in, data_in, we_in, tx_ready, gpio_in, rst_in);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr_in = a; data_in = d; we_in = 1'b1;
    tick();
    we_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
    addr_in = 8'hF3; #1;
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL reset_status got=%h exp=01", data_out); end
    addr_in = 8'hF0; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_rd got=%h exp=00", data_out); end
    addr_in = 8'hF2; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=00", data_out); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out got=%h exp=00", gpio_out); end
  endtask

  task automatic test_ram();
    logic [7:0] a_top;
    logic [7:0] a_out;
    a_top = 8'(RAM_DEPTH - 1);
    a_out = 8'(RAM_DEPTH);
    wr(8'h03, 8'h5A);
    wr(a_top, 8'hA5);
    wr(8'h80, 8'h77);
    wr(a_out, 8'h66);
    addr_in = 8'h03; #1;
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL ram_03 got=%h exp=5a", data_out); end
    addr_in = a_top; #1;
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL ram_top got=%h exp=a5", data_out); end
    addr_in = 8'h80; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL unmapped_80 got=%h exp=00", data_out); end
    addr_in = a_out; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL unmapped_depth got=%h exp=00", data_out); end
    addr_in = 8'hEF; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL unmapped_ef got=%h exp=00", data_out); end
  endtask

  task automatic test_gpio();
    gpio_in = 8'hC3;
    addr_in = 8'hF1; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL gpio_in_c0 got=%h exp=00", data_out); end
    tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL gpio_in_c1 got=%h exp=00", data_out); end
    tick();
    checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL gpio_in_c2 got=%h exp=c3", data_out); end
    wr(8'hF1, 8'h00);
    addr_in = 8'hF1; #1;
    checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL gpio_in_ro got=%h exp=c3", data_out); end
    addr_in = 8'hF0; data_in = 8'h3C; we_in = 1'b1; #1;
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL gpio_out_pre got=%h exp=00", gpio_out); end
    tick();
    we_in = 1'b0;
    checks++; if (gpio_out !== 8'h3C) begin errors++; $display("FAIL gpio_out got=%h exp=3c", gpio_out); end
    #1;
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL gpio_out_rd got=%h exp=3c", data_out); end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_ready = 1'b0;
    wr(8'hF2, 8'h11); wr(8'hF2, 8'h22); wr(8'hF2, 8'h33); wr(8'hF2, 8'h44); wr(8'hF2, 8'h55);
    addr_in = 8'hF3; #1;
    checks++; if (data_out !== 8'h0A) begin errors++; $display("FAIL ovf_status got=%h exp=0a", data_out); end
    addr_in = 8'hF2; #1;
    checks++; if (data_out !== 8'h04) begin errors++; $display("FAIL ovf_count got=%h exp=04", data_out); end
    checks++; if (tx_data !== 8'h11) begin errors++; $display("FAIL ovf_hold got=%h exp=11", tx_data); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b[i]);
      end
      tick();
    end
    addr_in = 8'hF3; #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", tx_valid); end
    checks++; if (data_out !== 8'h09) begin errors++; $display("FAIL drain_status got=%h exp=09", data_out); end
    checks++; if (tx_data !== 8'h44) begin errors++; $display("FAIL empty_hold got=%h exp=44", tx_data); end
    tx_ready = 1'b0;
    wr(8'hF3, 8'h00);
    addr_in = 8'hF3; #1;
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL ovf_clear got=%h exp=01", data_out); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_b [4];
    exp_b = '{8'hBB, 8'hCC, 8'hDD, 8'h99};
    tx_ready = 1'b0;
    wr(8'hF2, 8'hAA); wr(8'hF2, 8'hBB); wr(8'hF2, 8'hCC); wr(8'hF2, 8'hDD);
    addr_in = 8'hF3; #1;
    checks++; if (data_out !== 8'h02) begin errors++; $display("FAIL full_status got=%h exp=02", data_out); end
    tx_ready = 1'b1;
    addr_in = 8'hF2; data_in = 8'h99; we_in = 1'b1; #1;
    checks++; if (tx_data !== 8'hAA) begin errors++; $display("FAIL pp_head got=%h exp=aa", tx_data); end
    tick();
    we_in = 1'b0;
    addr_in = 8'hF3; #1;
    checks++; if (data_out !== 8'h02) begin errors++; $display("FAIL pp_status got=%h exp=02", data_out); end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++; $display("FAIL pp_drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b[i]);
      end
      tick();
    end
    #1;
    checks++; if (data_out !== 8'h01 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL pp_end got=%h/%b exp=01/0", data_out, tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_timer();
`ifdef MINIBYTE_TIMER_EN
    logic [7:0] seq [4];
    seq = '{8'h03, 8'h02, 8'h01, 8'h03};
    wr(8'hF4, 8'h03);
    for (int i = 0; i < 4; i++) begin
      addr_in = 8'hF5; #1;
      checks++; if (data_out !== seq[i]) begin errors++; $display("FAIL timer_cnt_%0d got=%h exp=%h", i, data_out, seq[i]); end
      addr_in = 8'hF3; #1;
      checks++; if (data_out[2] !== (i == 3)) begin errors++; $display("FAIL timer_exp_%0d got=%b exp=%b", i, data_out[2], i == 3); end
      if (i < 3) tick();
    end
    wr(8'hF5, 8'h00);
    addr_in = 8'hF3; #1;
    checks++; if (data_out[2] !== 1'b0) begin errors++; $display("FAIL timer_clear got=%b exp=0", data_out[2]); end
    tick();
    addr_in = 8'hF5; #1;
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL timer_pre_wrap got=%h exp=01", data_out); end
    wr(8'hF5, 8'h00);
    addr_in = 8'hF3; #1;
    checks++; if (data_out[2] !== 1'b1) begin errors++; $display("FAIL timer_set_wins got=%b exp=1", data_out[2]); end
    wr(8'hF4, 8'h00);
    tick(); tick();
    addr_in = 8'hF5; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL timer_frozen got=%h exp=00", data_out); end
`else
    wr(8'hF4, 8'h55);
    wr(8'hF5, 8'h01);
    tick(); tick();
    addr_in = 8'hF4; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL notimer_f4 got=%h exp=00", data_out); end
    addr_in = 8'hF5; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL notimer_f5 got=%h exp=00", data_out); end
    addr_in = 8'hF3; #1;
    checks++; if (data_out[2] !== 1'b0) begin errors++; $display("FAIL notimer_exp got=%b exp=0", data_out[2]); end
`endif
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    wr(8'hF2, 8'h01); wr(8'hF2, 8'h02); wr(8'hF2, 8'h03);
    wr(8'hF0, 8'hAB);
    rst_in = 1'b1; addr_in = 8'hF0; data_in = 8'h5A; we_in = 1'b1;
    tick();
    rst_in = 1'b0; we_in = 1'b0;
    addr_in = 8'hF3; #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL midrst_fifo got=%b/%h exp=0/00", tx_valid, tx_data);
    end
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL midrst_gpio got=%h exp=00", gpio_out); end
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL midrst_status got=%h exp=01", data_out); end
  endtask

  task automatic test_random();
    int ready_pct;
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) wr(8'(i), 8'($urandom));
    for (int n = 0; n < 800; n++) begin
      logic [7:0] a;
      if (n % 64 == 0) ready_pct = (n % 128 == 0) ? 15 : 75;
      case ($urandom_range(0, 9))
        0, 1, 2: a = 8'($urandom_range(0, RAM_DEPTH - 1));
        3: a = 8'hF0;
        4: a = 8'hF1;
        5, 6: a = 8'hF2;
        7: a = 8'hF3;
        8: a = 8'hF4 + 8'($urandom_range(0, 1));
        default: begin
          a = 8'($urandom_range(RAM_DEPTH, 255));
          if (a >= 8'hF0 && a <= 8'hF5) a = 8'hF6;
        end
      endcase
      addr_in  = a;
      we_in    = 1'($urandom_range(0, 1));
      data_in  = (a == 8'hF4) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      tx_ready = ($urandom_range(0, 99) < ready_pct);
      gpio_in  = 8'($urandom);
      rst_in   = ($urandom_range(0, 199) == 0);
      @(negedge clk_in);
      checks++; if (data_out !== m_read(a)) begin errors++; $display("FAIL rnd_rd n=%0d addr=%h got=%h exp=%h", n, a, data_out, m_read(a)); end
      checks++; if (tx_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, tx_valid, m_q.size() > 0); end
      checks++; if (tx_data !== m_last_head) begin errors++; $display("FAIL rnd_txd n=%0d got=%h exp=%h", n, tx_data, m_last_head); end
      checks++; if (gpio_out !== m_gpio_out) begin errors++; $display("FAIL rnd_gpio n=%0d got=%h exp=%h", n, gpio_out, m_gpio_out); end
      tick();
    end
    rst_in = 1'b0; we_in = 1'b0; tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_fifo_overflow();
    test_push_pop_full();
    test_timer();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
